// File: rtl/pe_pkg.sv
// Shared types and constants for the row-stationary PE controller slice.
package pe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 6;
    localparam int TAPS       = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FILL,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/pe_row_ctrl_if.sv
// Weight, ifmap, incoming-psum and outgoing-psum valid/ready streams of one PE row.
interface pe_row_ctrl_if
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;

    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_data;

    logic              ps_in_valid;
    logic              ps_in_ready;
    logic [DATA_W-1:0] ps_in_data;

    logic              ps_out_valid;
    logic              ps_out_ready;
    logic [DATA_W-1:0] ps_out_data;

    // master = GLB/NoC side, slave = the PE controller
    modport master (
        output w_valid, w_data, input w_ready,
        output if_valid, if_data, input if_ready,
        output ps_in_valid, ps_in_data, input ps_in_ready,
        input ps_out_valid, ps_out_data, output ps_out_ready
    );

    modport slave (
        input w_valid, w_data, output w_ready,
        input if_valid, if_data, output if_ready,
        input ps_in_valid, ps_in_data, output ps_in_ready,
        output ps_out_valid, ps_out_data, input ps_out_ready
    );

endinterface

// File: rtl/pe_mac3.sv
// 3-tap multiply-accumulate: psum + w0*x0 + w1*x1 + w2*x2, wrapped to DATA_W bits.
module pe_mac3
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] psum,
    output logic [DATA_W-1:0] sum
);

    // The low DATA_W bits of a two's-complement sum of full-precision products
    // never depend on the upper bits, so the wrapped result is formed at DATA_W.
    always_comb begin
        sum = psum + (w0 * x0) + (w1 * x1) + (w2 * x2);
    end

endmodule

// File: rtl/pe_row_ctrl.sv
// Row-stationary PE controller: weight load, window fill, joint ifmap/psum streaming, flush.
module pe_row_ctrl
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_keep_w,
    output logic             cfg_err,
    output logic             busy,
    output logic             done,
    pe_row_ctrl_if.slave     bus
);

    state_t            state;
    logic [DATA_W-1:0] w0, w1, w2;
    logic [DATA_W-1:0] x0, x1;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] mac_sum;
    logic              out_free;
    logic              out_hs;
    logic              fire;

    pe_mac3 #(.DATA_W(DATA_W)) u_mac (
        .w0   (w0),
        .w1   (w1),
        .w2   (w2),
        .x0   (x0),
        .x1   (x1),
        .x2   (bus.if_data),
        .psum (bus.ps_in_data),
        .sum  (mac_sum)
    );

    always_comb begin
        out_free = !out_valid || bus.ps_out_ready;
        out_hs   = out_valid && bus.ps_out_ready;
        fire     = (state == RUN) && bus.if_valid && bus.ps_in_valid && out_free;
    end

    // ifmap and psum are consumed together so window position and psum index stay aligned
    assign bus.w_ready      = (state == LOAD_W);
    assign bus.if_ready     = (state == FILL) || ((state == RUN) && bus.ps_in_valid && out_free);
    assign bus.ps_in_ready  = (state == RUN) && bus.if_valid && out_free;
    assign bus.ps_out_valid = out_valid;
    assign bus.ps_out_data  = out_data;
    assign busy             = (state != IDLE);
    assign done             = (state == FLUSH) && out_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            x0        <= '0;
            x1        <= '0;
            len       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len < LEN_W'(TAPS)) begin
                            cfg_err <= 1'b1;
                        end else begin
                            len   <= cfg_len;
                            cnt   <= '0;
                            state <= cfg_keep_w ? FILL : LOAD_W;
                        end
                    end
                end
                LOAD_W: begin
                    if (bus.w_valid) begin
                        if (cnt == LEN_W'(0)) begin
                            w0 <= bus.w_data;
                        end else if (cnt == LEN_W'(1)) begin
                            w1 <= bus.w_data;
                        end else begin
                            w2 <= bus.w_data;
                        end
                        if (cnt == LEN_W'(TAPS - 1)) begin
                            cnt   <= '0;
                            state <= FILL;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (bus.if_valid) begin
                        if (cnt == LEN_W'(0)) begin
                            x0  <= bus.if_data;
                            cnt <= LEN_W'(1);
                        end else begin
                            x1    <= bus.if_data;
                            cnt   <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        out_data  <= mac_sum;
                        out_valid <= 1'b1;
                        x0        <= x1;
                        x1        <= bus.if_data;
                        cnt       <= cnt + LEN_W'(1);
                        // a row of L samples yields L-2 windows
                        if (cnt == len - LEN_W'(TAPS)) begin
                            state <= FLUSH;
                        end
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pe_row_ctrl.md
Name: pe_row_ctrl

Overview:
Row-stationary PE controller for one 3-tap filter row. It loads three weights, streams an ifmap row through a 3-deep sliding window and adds each window's dot product to an incoming partial sum. It emits one outgoing partial sum per window, using valid/ready handshakes on every stream. It sits between the GLB/NoC streams and the PE's 3-tap multiply-accumulate datapath, and owns all sequencing, window shifting and backpressure.

Parameters:
DATA_W, 16, width of weights, ifmap, psum; all signed two's complement
LEN_W, 6, width of the ifmap row length field (max row length 2^LEN_W-1)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  start pulse, sampled only in IDLE
cfg_len  in  LEN_W  ifmap row length L, sampled with cfg_start
cfg_keep_w  in  1  1 = reuse held weights and skip LOAD_W
cfg_err  out  1  one-cycle pulse: start rejected
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on final psum output handshake
w_valid / w_ready / w_data  in / out / DATA_W  weight stream
if_valid / if_ready / if_data  in / out / DATA_W  ifmap stream
ps_in_valid / ps_in_ready / ps_in_data  in / out / DATA_W  incoming psum stream
ps_out_valid / ps_out_ready / ps_out_data  out / in / DATA_W  outgoing psum stream

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE; weights, window regs, counters, ps_out_data = 0. All valid, ready, busy, done and cfg_err outputs are 0.
- States: IDLE, LOAD_W, FILL, RUN, FLUSH.
- IDLE: cfg_start with L<3 → cfg_err pulse next cycle, remain IDLE. cfg_start with L>=3 → LOAD_W, or FILL if cfg_keep_w=1. cfg_start is ignored outside IDLE.
- LOAD_W: w_ready=1. Accepts 3 weights in order w0,w1,w2, then → FILL. Weights persist until the next LOAD_W or reset.
- FILL: if_ready=1. Accepts 2 ifmap samples into window regs x0,x1, then → RUN.
- RUN: joint handshake. Define out_free = !ps_out_valid || ps_out_ready.
  - if_ready = ps_in_valid && out_free; ps_in_ready = if_valid && out_free. Both fire in the same cycle or neither does.
  - On fire: ps_out_data <= ps_in_data + w0*x0 + w1*x1 + w2*if_data; ps_out_valid <= 1; x0 <= x1; x1 <= if_data; out_cnt increments.
  - Latency is one cycle: the result is visible the cycle after the fire.
- Arithmetic: full-precision products summed, then truncated to the low DATA_W bits (wrap, no saturation).
- Output register: holds data stable while ps_out_valid && !ps_out_ready. Clears valid on handshake when no new fire occurs that cycle. Back-to-back throughput is 1 psum/cycle.
- After the (L-2)th fire → FLUSH. FLUSH waits for the final output handshake, pulses done in that same cycle, then → IDLE.
- No input is accepted in FLUSH or IDLE: all input readies are 0.
- A start arriving in the same cycle as the done pulse is ignored; the state is not yet IDLE.
- Reset asserted mid-operation aborts immediately. Held weights are lost; a following cfg_keep_w=1 uses zero weights.

Decomposition:
- Shared package pe_pkg holds:
  - DATA_W and LEN_W defaults
  - state enum (IDLE, LOAD_W, FILL, RUN, FLUSH)
  - TAPS=3 constant
- One natural combinational sub-module, pe_mac3: inputs w0..w2, x0..x2, psum; output truncated sum. The controller instantiates one and owns all registers.

Test Plan:
- Basic row: weights 1,2,3; L=5; ifmap 1,2,3,4,5; psum 0,0,0; ps_out_ready=1 → outputs 14,20,26 on consecutive cycles; done pulses with the 26 handshake; busy then drops.
- Psum chaining plus signs: weights 1,2,3; ifmap 1..5; psum 10,-20,30 → outputs 24,0,56.
- Backpressure: same stimulus as the basic row, ps_out_ready held 0 for 3 cycles after the first output → 14 held stable, if_ready and ps_in_ready low while the register is full, no loss or duplication; final sequence 14,20,26.
- Weight reuse and overflow: run with w0=0x4000, w1=0, w2=0 and L=3, ifmap 4,0,0, psum 0 → output 0x0000 (wrap). Then cfg_keep_w=1 with L=3, ifmap 1,0,0, psum 5 → output 0x4005 with no w_ready assertion.
- Illegal/ignored config: cfg_start with L=2 → cfg_err pulse, no busy. cfg_start during RUN → no effect on the output sequence.
- Reset mid-RUN: assert rst_n=0 after the first output → all outputs 0 immediately. A new L=3 run with cfg_keep_w=1 and psum 7 → output 7.
